// File: rtl/nibble_bus_memory.sv
// DEPTH x 4-bit flop memory written by a two-phase CPU bus (address cycle, then data cycle).
// Optional serial loader port group compiled in with `define NBM_LOADER_EN.
module nibble_bus_memory #(
  parameter int         DEPTH    = 32,
  parameter logic [3:0] INIT_VAL = 4'h0
) (
  input  logic                     clk,
  input  logic                     rst_p,
  input  logic [6:0]               bus_addr,
  input  logic                     bus_wcyc,
`ifdef NBM_LOADER_EN
  input  logic                     load_en,
  input  logic                     load_valid,
  input  logic [3:0]               load_data,
  output logic [$clog2(DEPTH)-1:0] load_ptr,
`endif
  output logic [3:0]               rdata,
  output logic                     wr_strobe,
  output logic                     err_oor,
  output logic                     err_proto
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  typedef enum logic {W_IDLE = 1'b0, W_DATA = 1'b1} wstate_t;

  wstate_t    state_r, state_nxt_s;
  logic [3:0] mem_r [DEPTH];
  logic [6:0] waddr_r, waddr_nxt_s;
  logic       mem_we_s, oor_set_s, proto_set_s, hold_s;
  logic       wr_strobe_r, err_oor_r, err_proto_r;

  function automatic logic in_range(input logic [6:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  // Combinational read port; out-of-range addresses read as zero
  always_comb begin
    if (in_range(bus_addr)) begin
      rdata = mem_r[bus_addr[AW-1:0]];
    end else begin
      rdata = 4'h0;
    end
  end

`ifdef NBM_LOADER_EN
  logic [AW-1:0] load_ptr_r;
  logic          load_we_s;

  assign hold_s    = load_en;
  assign load_we_s = load_en & load_valid;
  assign load_ptr  = load_ptr_r;

  // Loader pointer: advances per accepted nibble, cleared whenever the loader is idle
  always_ff @(posedge clk) begin
    if (rst_p || !load_en) begin
      load_ptr_r <= {AW{1'b0}};
    end else if (load_valid) begin
      load_ptr_r <= (load_ptr_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : load_ptr_r + AW'(1);
    end else begin
      load_ptr_r <= load_ptr_r;
    end
  end
`else
  assign hold_s = 1'b0;
`endif

  // Write FSM next state; an active loader forces the bus side idle and drops any pending write
  always_comb begin
    state_nxt_s = state_r;
    waddr_nxt_s = waddr_r;
    mem_we_s    = 1'b0;
    oor_set_s   = 1'b0;
    proto_set_s = 1'b0;
    if (hold_s) begin
      state_nxt_s = W_IDLE;
    end else begin
      case (state_r)
        W_IDLE: begin
          if (bus_wcyc) begin
            waddr_nxt_s = bus_addr;
            state_nxt_s = W_DATA;
          end else begin
            state_nxt_s = W_IDLE;
          end
        end
        W_DATA: begin
          state_nxt_s = W_IDLE;
          if (!bus_wcyc) begin
            proto_set_s = 1'b1;
          end else if (in_range(waddr_r)) begin
            mem_we_s = 1'b1;
          end else begin
            oor_set_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = W_IDLE;
        end
      endcase
    end
  end

  // Memory array: reset fill, bus write commit, loader write
  always_ff @(posedge clk) begin
    if (rst_p) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= INIT_VAL;
      end
    end else if (mem_we_s) begin
      mem_r[waddr_r[AW-1:0]] <= bus_addr[3:0];
`ifdef NBM_LOADER_EN
    end else if (load_we_s) begin
      mem_r[load_ptr_r] <= load_data;
`endif
    end
  end

  // FSM state, latched write address, strobe and sticky error flags
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_r     <= W_IDLE;
      waddr_r     <= 7'h00;
      wr_strobe_r <= 1'b0;
      err_oor_r   <= 1'b0;
      err_proto_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      waddr_r     <= waddr_nxt_s;
      wr_strobe_r <= mem_we_s;
      err_oor_r   <= err_oor_r | oor_set_s;
      err_proto_r <= err_proto_r | proto_set_s;
    end
  end

  assign wr_strobe = wr_strobe_r;
  assign err_oor   = err_oor_r;
  assign err_proto = err_proto_r;

endmodule

// File: tb/tb_nibble_bus_memory.sv
// Directed scoreboard bench for nibble_bus_memory (DEPTH=32, INIT_VAL=0).
// Loader scenario is included when NBM_LOADER_EN is defined.
module tb_nibble_bus_memory;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst_p = 1'b1;
  logic [6:0] bus_addr = 7'h00;
  logic       bus_wcyc = 1'b0;
  logic [3:0] rdata;
  logic       wr_strobe, err_oor, err_proto;
`ifdef NBM_LOADER_EN
  logic       load_en = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = 4'h0;
  logic [4:0] load_ptr;
`endif

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  logic [3:0] model [DEPTH];
  logic [7:0] exp_q [$];
  logic       exp_oor = 1'b0;
  logic       exp_proto = 1'b0;

  nibble_bus_memory #(.DEPTH(DEPTH), .INIT_VAL(4'h0)) dut (
    .clk(clk), .rst_p(rst_p), .bus_addr(bus_addr), .bus_wcyc(bus_wcyc),
`ifdef NBM_LOADER_EN
    .load_en(load_en), .load_valid(load_valid), .load_data(load_data), .load_ptr(load_ptr),
`endif
    .rdata(rdata), .wr_strobe(wr_strobe), .err_oor(err_oor), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_oor"}, 8'(err_oor), 8'(exp_oor));
    chk({tag, "_proto"}, 8'(err_proto), 8'(exp_proto));
  endtask

  // Combinational read in the current cycle; expectation comes from the bench model
  task automatic rd(input logic [6:0] a);
    bus_addr = a;
    bus_wcyc = 1'b0;
    exp_q.push_back((a < 7'(DEPTH)) ? 8'(model[a[4:0]]) : 8'h00);
    #1;
    chk($sformatf("rd_%02h", a), 8'(rdata), exp_q.pop_front());
  endtask

  // Address cycle then data cycle; wr_strobe is checked right after the data edge
  task automatic wr(input logic [6:0] a, input logic [3:0] d);
    bus_addr = a;
    bus_wcyc = 1'b1;
    tick();
    bus_addr = {3'b000, d};
    tick();
    bus_wcyc = 1'b0;
    if (a < 7'(DEPTH)) begin
      model[a[4:0]] = d;
      exp_q.push_back(8'h01);
    end else begin
      exp_oor = 1'b1;
      exp_q.push_back(8'h00);
    end
    chk($sformatf("wr_strobe_%02h", a), 8'(wr_strobe), exp_q.pop_front());
    tick();
    chk("wr_strobe_low", 8'(wr_strobe), 8'h00);
  endtask

  initial begin
    int s0;
    for (int i = 0; i < DEPTH; i++) model[i] = 4'h0;

    // Reset state
    tick();
    tick();
    rd(7'h05);
    chk("rst_strobe", 8'(wr_strobe), 8'h00);
    chk_flags("rst");
    rst_p = 1'b0;
    tick();

    // Basic write then same-cycle read
    s0 = strobe_cnt;
    wr(7'h05, 4'hA);
    chk("strobe_cnt_basic", 8'(strobe_cnt - s0), 8'h01);
    rd(7'h05);
    rd(7'h06);
    chk_flags("basic");

    // Last in-range word and first out-of-range read
    wr(7'h1F, 4'h7);
    rd(7'h1F);
    rd(7'h20);

    // Out-of-range write: no change, no strobe, sticky err_oor
    s0 = strobe_cnt;
    wr(7'h40, 4'h3);
    chk("strobe_cnt_oor", 8'(strobe_cnt - s0), 8'h00);
    rd(7'h40);
    rd(7'h00);
    chk_flags("oor");

    // Address phase not followed by data phase
    bus_addr = 7'h03;
    bus_wcyc = 1'b1;
    tick();
    bus_wcyc = 1'b0;
    tick();
    exp_proto = 1'b1;
    chk("proto_strobe", 8'(wr_strobe), 8'h00);
    chk_flags("proto");
    rd(7'h03);

    // wcyc held high four cycles pairs into two writes
    s0 = strobe_cnt;
    bus_wcyc = 1'b1;
    bus_addr = 7'h01; tick();
    bus_addr = 7'h06; tick();
    chk("hold_strobe_1", 8'(wr_strobe), 8'h01);
    bus_addr = 7'h02; tick();
    chk("hold_strobe_2", 8'(wr_strobe), 8'h00);
    bus_addr = 7'h09; tick();
    chk("hold_strobe_3", 8'(wr_strobe), 8'h01);
    bus_wcyc = 1'b0;
    model[1] = 4'h6;
    model[2] = 4'h9;
    tick();
    chk("strobe_cnt_hold", 8'(strobe_cnt - s0), 8'h02);
    rd(7'h01);
    rd(7'h02);
    rd(7'h06);
    rd(7'h09);
    chk_flags("hold");

`ifdef NBM_LOADER_EN
    // Loader rising during W_DATA abandons the write; bus pulses are ignored while loading
    begin
      logic [4:0] ptr = 5'd0;
      logic [3:0] d;
      bus_addr = 7'h0C;
      bus_wcyc = 1'b1;
      tick();
      s0 = strobe_cnt;
      load_en = 1'b1;
      load_valid = 1'b1;
      for (int i = 0; i < 33; i++) begin
        d = (i == 32) ? 4'h5 : 4'(i);
        load_data = d;
        bus_wcyc = (i % 2 == 0) ? 1'b1 : 1'b0;
        bus_addr = 7'h0B;
        tick();
        model[ptr] = d;
        ptr = ptr + 5'd1;
      end
      bus_wcyc = 1'b0;
      load_valid = 1'b0;
      chk("load_ptr_wrap", 8'(load_ptr), 8'(ptr));
      chk("load_strobe_cnt", 8'(strobe_cnt - s0), 8'h00);
      chk_flags("load");
      rd(7'h00);
      rd(7'h0C);
      rd(7'h1F);
      load_en = 1'b0;
      tick();
      chk("load_ptr_clr", 8'(load_ptr), 8'h00);
    end
`endif

    // Reset arriving mid-write
    bus_addr = 7'h04;
    bus_wcyc = 1'b1;
    tick();
    rst_p = 1'b1;
    bus_addr = 7'h0F;
    tick();
    for (int i = 0; i < DEPTH; i++) model[i] = 4'h0;
    exp_oor = 1'b0;
    exp_proto = 1'b0;
    rst_p = 1'b0;
    bus_wcyc = 1'b0;
    chk("midrst_strobe", 8'(wr_strobe), 8'h00);
    chk_flags("midrst");
    for (int i = 0; i < DEPTH; i++) rd(7'(i));
    tick();
    chk_flags("post_rst");
    wr(7'h07, 4'hC);
    rd(7'h07);
    rd(7'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
